input_overlay_compositor: RTL and testbench



---
 rtl/input_overlay_compositor.sv | 158 +++++++++++++++
 tb/tb_input_overlay_compositor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_overlay_compositor.sv
// Layer compositor (priority, colour key, window, cut-out) plus frame-latched, stretched button display.
// Latency: 2 clk pixel inputs -> overlay_on/rgb_data; col/row combinational; buttons_disp updates on frame_start only.
// No backpressure: one pixel per clk. Define INPUT_OVERLAY_SWAP_RB_EN to swap top/bottom colour fields (BGR ROMs).
module input_overlay_compositor #(
    parameter int                    NUM_LAYERS   = 4,
    parameter int                    COLOR_W      = 12,
    parameter logic [COLOR_W-1:0]    KEY_COLOR    = 12'h000,
    parameter logic [NUM_LAYERS-1:0] KEY_MASK     = 4'b1000,
    parameter logic [NUM_LAYERS-1:0] REGION_MASK  = 4'b1000,
    parameter int                    WIN_W        = 584,
    parameter int                    WIN_H        = 167,
    parameter int                    ORIGIN_X_DEF = 28,
    parameter int                    ORIGIN_Y_DEF = 156,
    parameter int                    NUM_BUTTONS  = 12,
    parameter int                    HOLD_FRAMES  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic                          frame_start,
    input  logic [9:0]                    origin_x_in,
    input  logic [9:0]                    origin_y_in,
    input  logic                          origin_load,
    input  logic                          cut,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_BUTTONS-1:0]        buttons_raw,
    output logic [9:0]                    col,
    output logic [9:0]                    row,
    output logic [NUM_BUTTONS-1:0]        buttons_disp,
    output logic                          overlay_on,
    output logic [COLOR_W-1:0]            rgb_data
);
    localparam int         F_W    = COLOR_W / 3;
    localparam int         CNT_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [9:0] OX_DEF = 10'(ORIGIN_X_DEF);
    localparam logic [9:0] OY_DEF = 10'(ORIGIN_Y_DEF);

    logic [9:0]             ox_q, ox_d, oy_q, oy_d;
    logic [9:0]             sx_q, sx_d, sy_q, sy_d;
    logic                   pend_q, pend_d;
    logic                   hit_q, hit_d;
    logic [COLOR_W-1:0]     pix_q, pix_d;
    logic                   overlay_on_q, overlay_on_d;
    logic [COLOR_W-1:0]     rgb_data_q, rgb_data_d;
    logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] buttons_disp_q, buttons_disp_d;
    logic                   in_win;
    logic [NUM_LAYERS-1:0]  vis;

    assign col = x - ox_q;
    assign row = y - oy_q;

    // 11-bit compares so a window touching the 1024 edge never wraps.
    assign in_win = ({1'b0, x} >= {1'b0, ox_q}) && ({1'b0, x} < ({1'b0, ox_q} + 11'(WIN_W))) &&
                    ({1'b0, y} >= {1'b0, oy_q}) && ({1'b0, y} < ({1'b0, oy_q} + 11'(WIN_H)));

    // The shadow only reaches the active origin on a frame boundary so a frame never tears.
    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        pend_d = pend_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        if (origin_load) begin
            sx_d   = origin_x_in;
            sy_d   = origin_y_in;
            pend_d = 1'b1;
        end
        if (frame_start && (origin_load || pend_q)) begin
            ox_d   = origin_load ? origin_x_in : sx_q;
            oy_d   = origin_load ? origin_y_in : sy_q;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis[i] = layer_on[i] && !cut &&
                     !(KEY_MASK[i] && (layer_rgb[i*COLOR_W +: COLOR_W] == KEY_COLOR)) &&
                     !(REGION_MASK[i] && !in_win);
        end
    end

    // Walk from lowest priority upward so the lowest visible index is written last.
    always_comb begin
        hit_d = 1'b0;
        pix_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vis[i]) begin
                hit_d = 1'b1;
                pix_d = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        overlay_on_d = hit_q;
`ifdef INPUT_OVERLAY_SWAP_RB_EN
        rgb_data_d   = {pix_q[F_W-1:0], pix_q[2*F_W-1:F_W], pix_q[COLOR_W-1:2*F_W]};
`else
        rgb_data_d   = pix_q;
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (frame_start) begin
                if (buttons_raw[i]) begin
                    cnt_d[i] = CNT_W'(HOLD_FRAMES);
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            buttons_disp_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ox_q           <= OX_DEF;
            oy_q           <= OY_DEF;
            sx_q           <= OX_DEF;
            sy_q           <= OY_DEF;
            pend_q         <= 1'b0;
            hit_q          <= 1'b0;
            pix_q          <= '0;
            overlay_on_q   <= 1'b0;
            rgb_data_q     <= '0;
            buttons_disp_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ox_q           <= ox_d;
            oy_q           <= oy_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            pend_q         <= pend_d;
            hit_q          <= hit_d;
            pix_q          <= pix_d;
            overlay_on_q   <= overlay_on_d;
            rgb_data_q     <= rgb_data_d;
            buttons_disp_q <= buttons_disp_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign overlay_on   = overlay_on_q;
    assign rgb_data     = rgb_data_q;
    assign buttons_disp = buttons_disp_q;

endmodule

// File: tb/tb_input_overlay_compositor.sv
// Scoreboard bench for input_overlay_compositor: directed corner cases followed by a long random run.
`timescale 1ns/1ps
module tb_input_overlay_compositor;
    localparam int         NL    = 4;
    localparam int         CW    = 12;
    localparam int         NB    = 12;
    localparam int         HOLD  = 8;
    localparam int         WW    = 584;
    localparam int         WH    = 167;
    localparam logic [3:0] KMASK = 4'b1000;
    localparam logic [3:0] RMASK = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [9:0]       x, y, origin_x_in, origin_y_in;
    logic             frame_start, origin_load, cut;
    logic [NL-1:0]    layer_on;
    logic [NL*CW-1:0] layer_rgb;
    logic [NB-1:0]    buttons_raw;
    logic [9:0]       col, row;
    logic [NB-1:0]    buttons_disp;
    logic             overlay_on;
    logic [CW-1:0]    rgb_data;

    input_overlay_compositor dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_start(frame_start),
        .origin_x_in(origin_x_in), .origin_y_in(origin_y_in), .origin_load(origin_load),
        .cut(cut), .layer_on(layer_on), .layer_rgb(layer_rgb), .buttons_raw(buttons_raw),
        .col(col), .row(row), .buttons_disp(buttons_disp), .overlay_on(overlay_on),
        .rgb_data(rgb_data)
    );

    typedef struct { int due; logic on; logic [CW-1:0] rgb; } pix_exp_t;
    typedef struct { int due; logic [NB-1:0] disp; } btn_exp_t;
    pix_exp_t pq[$];
    btn_exp_t bq[$];

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference state: active/pending origin and the frame index of each button's latest sampled press.
    int ax = 28, ay = 156, sx = 28, sy = 156;
    bit pend = 0;
    int fc = 0;
    int last_press [NB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        pix_exp_t p;
        btn_exp_t b;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            while (pq.size() > 0 && pq[0].due <= edge_n) begin
                p = pq.pop_front();
                chk("overlay_on", 32'(overlay_on), 32'(p.on));
                chk("rgb_data", 32'(rgb_data), 32'(p.rgb));
            end
            while (bq.size() > 0 && bq[0].due <= edge_n) begin
                b = bq.pop_front();
                chk("buttons_disp", 32'(buttons_disp), 32'(b.disp));
            end
        end
    end

    // Called just after a negedge with inputs set; checks col/row, queues expectations, advances the model.
    task automatic tick();
        int xi, yi, c;
        bit win, hit;
        logic [CW-1:0] pix, lay;
        pix_exp_t pe;
        btn_exp_t be;
        #1;
        c  = edge_n;
        xi = int'(x);
        yi = int'(y);
        chk("col", 32'(col), 32'((xi - ax + 1024) % 1024));
        chk("row", 32'(row), 32'((yi - ay + 1024) % 1024));

        win = (xi >= ax) && (xi < ax + WW) && (yi >= ay) && (yi < ay + WH);
        hit = 0;
        pix = '0;
        for (int i = 0; i < NL; i++) begin
            lay = layer_rgb[i*CW +: CW];
            if (!hit && layer_on[i] && !cut && !(KMASK[i] && lay == 12'h000) && !(RMASK[i] && !win)) begin
                hit = 1;
                pix = lay;
            end
        end
`ifdef INPUT_OVERLAY_SWAP_RB_EN
        pix = {pix[3:0], pix[7:4], pix[11:8]};
`endif
        pe.due = c + 2;
        pe.on  = hit;
        pe.rgb = pix;
        if (!reset_n) begin
            for (int i = 0; i < pq.size(); i++) begin
                pq[i].on  = 1'b0;
                pq[i].rgb = '0;
            end
            pe.on  = 1'b0;
            pe.rgb = '0;
        end
        pq.push_back(pe);

        if (!reset_n) begin
            fc = 0;
            for (int i = 0; i < NB; i++) last_press[i] = -100;
            ax = 28; ay = 156; pend = 0;
        end else begin
            if (frame_start) begin
                fc++;
                for (int i = 0; i < NB; i++) if (buttons_raw[i]) last_press[i] = fc;
            end
            if (origin_load) begin
                sx = int'(origin_x_in); sy = int'(origin_y_in); pend = 1;
            end
            if (frame_start && pend) begin
                ax = sx; ay = sy; pend = 0;
            end
        end
        be.due = c + 1;
        for (int i = 0; i < NB; i++) be.disp[i] = (fc - last_press[i]) < HOLD;
        bq.push_back(be);
        @(negedge clk);
    endtask

    task automatic rand_pix();
        x         = 10'($urandom_range(0, 700));
        y         = 10'($urandom_range(100, 400));
        layer_on  = 4'($urandom);
        layer_rgb = 48'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) layer_rgb[3*CW +: CW] = 12'h000;
        cut = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_pix();
            tick();
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        rand_pix();
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_pix(input int xv, input int yv, input logic [3:0] on, input logic [11:0] l3);
        x = 10'(xv); y = 10'(yv); layer_on = on; cut = 1'b0;
        layer_rgb = {l3, 12'h222, 12'h111, 12'h0F0};
        tick(); tick(); tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs [7];
        for (int i = 0; i < NB; i++) last_press[i] = -100;
        xs = '{27, 28, 29, 300, 611, 612, 613};
        reset_n = 1'b0; frame_start = 0; origin_load = 0; buttons_raw = '0;
        origin_x_in = '0; origin_y_in = '0;
        rand_pix();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rand_pix(); buttons_raw = 12'($urandom); frame_start = 1'($urandom); origin_load = 1'($urandom);
            tick();
        end
        reset_n = 1'b1; frame_start = 0; origin_load = 0; buttons_raw = '0;

        set_pix(100, 200, 4'b1111, 12'hABC);
        set_pix(100, 200, 4'b1000, 12'hABC);
        set_pix(100, 200, 4'b1000, 12'h000);
        foreach (xs[i]) set_pix(xs[i], 200, 4'b1000, 12'hABC);
        set_pix(300, 155, 4'b1000, 12'hABC);
        set_pix(300, 156, 4'b1000, 12'hABC);
        set_pix(300, 322, 4'b1000, 12'hABC);
        set_pix(300, 323, 4'b1000, 12'hABC);
        x = 10'd100; y = 10'd200; layer_on = 4'b1111; cut = 1'b1; tick(); tick(); tick();

        origin_x_in = 10'd100; origin_y_in = 10'd50; origin_load = 1'b1;
        rand_pix(); tick(); origin_load = 1'b0;
        origin_x_in = 10'd120; origin_y_in = 10'd60; origin_load = 1'b1;
        rand_pix(); tick(); origin_load = 1'b0;
        run(4); pulse_frame(); run(4);
        origin_x_in = 10'd28; origin_y_in = 10'd156; origin_load = 1'b1;
        pulse_frame(); origin_load = 1'b0; run(3);

        buttons_raw = '1; run(5); buttons_raw = '0; run(2); pulse_frame(); run(3);
        buttons_raw[0] = 1'b1; run(2); pulse_frame(); buttons_raw = '0;
        repeat (10) begin run(3); pulse_frame(); end
        buttons_raw[0] = 1'b1; pulse_frame(); buttons_raw = '0;
        repeat (3) begin run(2); pulse_frame(); end
        buttons_raw[0] = 1'b1; pulse_frame(); buttons_raw = '0;
        repeat (10) begin run(2); pulse_frame(); end
        buttons_raw[0] = 1'b1; pulse_frame(); buttons_raw = '0;
        repeat (3) begin run(2); pulse_frame(); end
        reset_n = 1'b0; run(1); reset_n = 1'b1; run(2); pulse_frame(); run(3);

        for (int i = 0; i < 3000; i++) begin
            rand_pix();
            buttons_raw = 12'($urandom) & 12'($urandom);
            frame_start = ($urandom_range(0, 19) == 0);
            origin_load = ($urandom_range(0, 49) == 0);
            origin_x_in = 10'($urandom_range(0, 700));
            origin_y_in = 10'($urandom_range(0, 400));
            reset_n     = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1; frame_start = 0; origin_load = 0; buttons_raw = '0;
        run(4);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(pq.size() + bq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
